// File: rtl/aes_req_arbiter.sv
// Round-robin front end that time-shares one AES-128 core between N_REQ requesters.
// A watchdog in WAIT turns a missing core Done into an error response.
module aes_req_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 31,
    localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int TW     = $clog2(TIMEOUT + 1)
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*DATA_W-1:0]   req_pt,
    input  logic [N_REQ*DATA_W-1:0]   req_key,
    output logic                      core_valid,
    output logic [DATA_W-1:0]         core_pt,
    output logic [DATA_W-1:0]         core_key,
    input  logic                      core_busy,
    input  logic                      core_done,
    input  logic [DATA_W-1:0]         core_ct,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [DATA_W-1:0]         rsp_ct,
    output logic                      rsp_err
);

    localparam int CW = IDW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e              state_q;
    logic [IDW-1:0]      rr_ptr_q;
    logic [IDW-1:0]      rr_ptr_d;
    logic [IDW-1:0]      id_q;
    logic [TW-1:0]       timer_q;
    logic [DATA_W-1:0]   pt_q;
    logic [DATA_W-1:0]   key_q;
    logic [DATA_W-1:0]   ct_q;
    logic                err_q;

    logic [DATA_W-1:0]   pt_arr  [N_REQ];
    logic [DATA_W-1:0]   key_arr [N_REQ];
    logic [CW-1:0]       cand;
    logic                grant_vld;
    logic [IDW-1:0]      grant_idx;
    logic                issue_go;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign pt_arr[gi]    = req_pt[gi*DATA_W +: DATA_W];
            assign key_arr[gi]   = req_key[gi*DATA_W +: DATA_W];
            assign req_ready[gi] = (state_q == S_IDLE) && grant_vld && (grant_idx == IDW'(gi));
        end
    endgenerate

    // Search rr_ptr, rr_ptr+1, ... (mod N_REQ); the first valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!grant_vld && req_valid[cand[IDW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IDW-1:0];
            end
        end
    end

    assign rr_ptr_d   = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + IDW'(1);
    assign issue_go   = (state_q == S_ISSUE) && !core_busy && !core_done;

    assign core_valid = issue_go;
    assign core_pt    = (state_q != S_IDLE) ? pt_q  : '0;
    assign core_key   = (state_q != S_IDLE) ? key_q : '0;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = id_q;
    assign rsp_ct     = ct_q;
    assign rsp_err    = err_q;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            timer_q  <= '0;
            pt_q     <= '0;
            key_q    <= '0;
            ct_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        pt_q    <= pt_arr[grant_idx];
                        key_q   <= key_arr[grant_idx];
                        id_q    <= grant_idx;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_go) begin
                        timer_q <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    timer_q <= timer_q + TW'(1);
                    // Done takes priority over an expiry in the same cycle.
                    if (core_done) begin
                        ct_q    <= core_ct;
                        err_q   <= 1'b0;
                        state_q <= S_RESP;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        ct_q    <= '0;
                        err_q   <= 1'b1;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
